// File: rtl/host_queue_pkg.sv
// Shared constants and types for the host output descriptor queue.
// Descriptor layout: {inverse-map flag, flowid, bufid}.
package host_queue_pkg;

   localparam int unsigned DESC_W     = 24;
   localparam int unsigned FLAG_BIT   = 23;
   localparam int unsigned FLOWID_MSB = 22;
   localparam int unsigned FLOWID_LSB = 9;
   localparam int unsigned BUFID_MSB  = 8;
   localparam int unsigned BUFID_LSB  = 0;
   localparam int unsigned FLOWID_W   = FLOWID_MSB - FLOWID_LSB + 1;
   localparam int unsigned BUFID_W    = BUFID_MSB - BUFID_LSB + 1;
   localparam int unsigned DROP_CNT_W = 16;

   typedef enum logic [1:0] {
      IDLE_S     = 2'b00,
      WAIT_ACK_S = 2'b01
   } rd_state_e;

   typedef struct packed {
      logic                flag;
      logic [FLOWID_W-1:0] flowid;
      logic [BUFID_W-1:0]  bufid;
   } desc_t;

   function automatic desc_t unpack_desc(input logic [DESC_W-1:0] word);
      desc_t d;
      d.flag   = word[FLAG_BIT];
      d.flowid = word[FLOWID_MSB:FLOWID_LSB];
      d.bufid  = word[BUFID_MSB:BUFID_LSB];
      return d;
   endfunction

endpackage

// File: rtl/host_queue_fifo.sv
// Descriptor storage: circular array, occupancy counter, registered full flag,
// and overflow pulse / saturating drop counter for writes that arrive while full.
module host_queue_fifo
   import host_queue_pkg::*;
#(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned AW    = 4
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic [DESC_W-1:0]     wdata_i,
   input  logic                  wr_i,
   input  logic                  pop_i,
   output logic [DESC_W-1:0]     rdata_c_o,
   output logic [AW:0]           used_o,
   output logic                  full_o,
   output logic                  overflow_o,
   output logic [DROP_CNT_W-1:0] drop_cnt_o
);

   logic [DESC_W-1:0]     mem_q [DEPTH];
   logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
   logic [AW:0]           used_q, used_d;
   logic                  full_q, full_d;
   logic                  overflow_q, overflow_d;
   logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;
   logic                  wr_ok_c, drop_c, pop_ok_c;

   // Full is the registered flag, so a write colliding with a pop at full is still dropped.
   assign wr_ok_c  = wr_i & ~full_q;
   assign drop_c   = wr_i & full_q;
   assign pop_ok_c = pop_i & (used_q != '0);

   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      used_d     = used_q;
      drop_cnt_d = drop_cnt_q;
      overflow_d = drop_c;
      if (wr_ok_c)  wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_ok_c) rd_ptr_d = rd_ptr_q + AW'(1);
      case ({wr_ok_c, pop_ok_c})
         2'b10:   used_d = used_q + (AW+1)'(1);
         2'b01:   used_d = used_q - (AW+1)'(1);
         default: used_d = used_q;
      endcase
      full_d = (used_d == (AW+1)'(DEPTH));
      if (drop_c && (drop_cnt_q != '1)) drop_cnt_d = drop_cnt_q + DROP_CNT_W'(1);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         used_q     <= '0;
         full_q     <= 1'b0;
         overflow_q <= 1'b0;
         drop_cnt_q <= '0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         used_q     <= used_d;
         full_q     <= full_d;
         overflow_q <= overflow_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

   // Array contents are left as-is on reset; the pointers make them unreachable.
   always_ff @(posedge clk_i) begin
      if (wr_ok_c) mem_q[wr_ptr_q] <= wdata_i;
   end

   assign rdata_c_o  = mem_q[rd_ptr_q];
   assign used_o     = used_q;
   assign full_o     = full_q;
   assign overflow_o = overflow_q;
   assign drop_cnt_o = drop_cnt_q;

endmodule

// File: rtl/host_output_queue.sv
// Host output descriptor queue: buffers descriptors and presents them one at a
// time to host transmit, holding each until a one-cycle acknowledge.
module host_output_queue
   import host_queue_pkg::*;
#(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned AW    = 4
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic [DESC_W-1:0]     iv_fifo_wdata,
   input  logic                  i_fifo_wr,
   output logic [BUFID_W-1:0]    ov_bufid,
   output logic [FLOWID_W-1:0]   ov_flowid,
   output logic                  o_inverse_map_flag,
   output logic                  o_descriptor_wr,
   input  logic                  i_descriptor_ack,
   output logic [AW:0]           ov_queue_used,
   output logic                  o_queue_full,
   output logic                  o_overflow,
   output logic [DROP_CNT_W-1:0] ov_drop_cnt
);

   rd_state_e         state_q, state_d;
   desc_t             desc_q, desc_d;
   logic              desc_wr_q, desc_wr_d;
   logic              pop_c;
   logic [DESC_W-1:0] rdata_c;

   host_queue_fifo #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_fifo (
      .clk_i      (i_clk),
      .rst_i      (i_rst),
      .wdata_i    (iv_fifo_wdata),
      .wr_i       (i_fifo_wr),
      .pop_i      (pop_c),
      .rdata_c_o  (rdata_c),
      .used_o     (ov_queue_used),
      .full_o     (o_queue_full),
      .overflow_o (o_overflow),
      .drop_cnt_o (ov_drop_cnt)
   );

   assign pop_c = (state_q == IDLE_S) && (ov_queue_used != '0);

   always_ff @(posedge i_clk) begin
      if (i_rst) state_q <= IDLE_S;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE_S:     if (pop_c) state_d = WAIT_ACK_S;
         WAIT_ACK_S: if (i_descriptor_ack) state_d = IDLE_S;
         default:    state_d = IDLE_S;
      endcase
   end

   // Fields keep their last value when idle; only the valid flag drops.
   always_comb begin
      desc_d    = desc_q;
      desc_wr_d = 1'b0;
      case (state_q)
         IDLE_S: begin
            if (pop_c) begin
               desc_d    = unpack_desc(rdata_c);
               desc_wr_d = 1'b1;
            end
         end
         WAIT_ACK_S: desc_wr_d = ~i_descriptor_ack;
         default:    desc_wr_d = 1'b0;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         desc_q    <= '0;
         desc_wr_q <= 1'b0;
      end else begin
         desc_q    <= desc_d;
         desc_wr_q <= desc_wr_d;
      end
   end

   assign ov_bufid           = desc_q.bufid;
   assign ov_flowid          = desc_q.flowid;
   assign o_inverse_map_flag = desc_q.flag;
   assign o_descriptor_wr    = desc_wr_q;

endmodule

// File: tb/tb_host_output_queue.sv
// Directed bench for host_output_queue: presentation, ordering, overflow,
// simultaneous write/pop, spurious ack and reset while waiting for ack.
module tb_host_output_queue;

   logic        clk = 1'b0;
   logic        rst;
   logic [23:0] wdata;
   logic        wr;
   logic        ack;
   logic [8:0]  bufid;
   logic [13:0] flowid;
   logic        flag;
   logic        desc_wr;
   logic [4:0]  used;
   logic        full;
   logic        overflow;
   logic [15:0] drop_cnt;

   int vectors    = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   host_output_queue #(.DEPTH(16), .AW(4)) dut (
      .i_clk              (clk),
      .i_rst              (rst),
      .iv_fifo_wdata      (wdata),
      .i_fifo_wr          (wr),
      .ov_bufid           (bufid),
      .ov_flowid          (flowid),
      .o_inverse_map_flag (flag),
      .o_descriptor_wr    (desc_wr),
      .i_descriptor_ack   (ack),
      .ov_queue_used      (used),
      .o_queue_full       (full),
      .o_overflow         (overflow),
      .ov_drop_cnt        (drop_cnt)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; wr = 1'b0; ack = 1'b0; wdata = '0;
      step(); step();
      rst = 1'b0;
      vectors++; if ({desc_wr, full, overflow} !== 3'b000) begin miscompares++; $display("FAIL reset_flags: got %b want 000", {desc_wr, full, overflow}); end
      vectors++; if (used !== 5'd0) begin miscompares++; $display("FAIL reset_used: got %0d want 0", used); end
      vectors++; if (drop_cnt !== 16'd0) begin miscompares++; $display("FAIL reset_drop_cnt: got %0d want 0", drop_cnt); end
      vectors++; if ({flag, flowid, bufid} !== 24'h0) begin miscompares++; $display("FAIL reset_fields: got %h want 000000", {flag, flowid, bufid}); end
   endtask

   task automatic test_single();
      wdata = 24'h812345; wr = 1'b1;
      step();
      wr = 1'b0;
      vectors++; if ({desc_wr, used} !== {1'b0, 5'd1}) begin miscompares++; $display("FAIL single_after_write: got wr=%b used=%0d want wr=0 used=1", desc_wr, used); end
      step();
      vectors++; if (desc_wr !== 1'b1) begin miscompares++; $display("FAIL single_present: got %b want 1", desc_wr); end
      vectors++; if (flag !== 1'b1) begin miscompares++; $display("FAIL single_flag: got %b want 1", flag); end
      vectors++; if (flowid !== 14'h0091) begin miscompares++; $display("FAIL single_flowid: got %h want 0091", flowid); end
      vectors++; if (bufid !== 9'h145) begin miscompares++; $display("FAIL single_bufid: got %h want 145", bufid); end
      vectors++; if (used !== 5'd0) begin miscompares++; $display("FAIL single_used_pop: got %0d want 0", used); end
      ack = 1'b1;
      step();
      ack = 1'b0;
      vectors++; if ({desc_wr, used} !== {1'b0, 5'd0}) begin miscompares++; $display("FAIL single_ack: got wr=%b used=%0d want wr=0 used=0", desc_wr, used); end
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 17; i++) begin
         wdata = 24'(i); wr = 1'b1;
         step();
      end
      wr = 1'b0;
      vectors++; if ({full, used} !== {1'b1, 5'd16}) begin miscompares++; $display("FAIL fill_full: got full=%b used=%0d want full=1 used=16", full, used); end
      vectors++; if ({desc_wr, overflow, bufid} !== {1'b1, 1'b0, 9'd0}) begin miscompares++; $display("FAIL fill_head: got wr=%b ovf=%b bufid=%h want 1 0 000", desc_wr, overflow, bufid); end
      wdata = 24'h0000FF; wr = 1'b1;
      step();
      wr = 1'b0;
      vectors++; if ({overflow, drop_cnt} !== {1'b1, 16'd1}) begin miscompares++; $display("FAIL drop_pulse: got ovf=%b cnt=%0d want 1 1", overflow, drop_cnt); end
      vectors++; if (used !== 5'd16) begin miscompares++; $display("FAIL drop_used: got %0d want 16", used); end
      step();
      vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL drop_pulse_width: got %b want 0", overflow); end
      for (int k = 0; k < 17; k++) begin
         vectors++; if ({desc_wr, bufid} !== {1'b1, 9'(k)}) begin miscompares++; $display("FAIL fifo_order_%0d: got wr=%b bufid=%h want 1 %h", k, desc_wr, bufid, 9'(k)); end
         ack = 1'b1;
         step();
         ack = 1'b0;
         vectors++; if (desc_wr !== 1'b0) begin miscompares++; $display("FAIL order_ack_%0d: got %b want 0", k, desc_wr); end
         step();
      end
      vectors++; if ({desc_wr, full, used} !== {1'b0, 1'b0, 5'd0}) begin miscompares++; $display("FAIL fill_drained: got wr=%b full=%b used=%0d want 0 0 0", desc_wr, full, used); end
   endtask

   task automatic test_delayed_ack();
      wdata = 24'h5A5A5A; wr = 1'b1;
      step();
      wdata = 24'h000123;
      step();
      wr = 1'b0;
      for (int c = 0; c < 10; c++) begin
         vectors++; if ({desc_wr, flag, flowid, bufid, used} !== {1'b1, 1'b0, 14'h2D2D, 9'h05A, 5'd1}) begin miscompares++; $display("FAIL hold_%0d: got wr=%b f=%b fl=%h b=%h u=%0d want 1 0 2d2d 05a 1", c, desc_wr, flag, flowid, bufid, used); end
         step();
      end
      ack = 1'b1;
      step();
      ack = 1'b0;
      vectors++; if ({desc_wr, used} !== {1'b0, 5'd1}) begin miscompares++; $display("FAIL delayed_ack_one_pop: got wr=%b used=%0d want 0 1", desc_wr, used); end
      step();
      vectors++; if ({desc_wr, bufid, used} !== {1'b1, 9'h123, 5'd0}) begin miscompares++; $display("FAIL delayed_next: got wr=%b bufid=%h used=%0d want 1 123 0", desc_wr, bufid, used); end
      ack = 1'b1;
      step();
      ack = 1'b0;
   endtask

   task automatic test_simultaneous();
      for (int i = 0; i < 6; i++) begin
         wdata = 24'(8'h10 + i); wr = 1'b1;
         step();
      end
      wr = 1'b0;
      ack = 1'b1;
      step();
      ack = 1'b0;
      vectors++; if ({desc_wr, used} !== {1'b0, 5'd5}) begin miscompares++; $display("FAIL simul_setup: got wr=%b used=%0d want 0 5", desc_wr, used); end
      wdata = 24'h000016; wr = 1'b1;
      step();
      wr = 1'b0;
      vectors++; if ({desc_wr, bufid, used} !== {1'b1, 9'h011, 5'd5}) begin miscompares++; $display("FAIL simul_used5: got wr=%b bufid=%h used=%0d want 1 011 5", desc_wr, bufid, used); end
      for (int i = 0; i < 11; i++) begin
         wdata = 24'(8'h17 + i); wr = 1'b1;
         step();
      end
      wr = 1'b0;
      ack = 1'b1;
      step();
      ack = 1'b0;
      vectors++; if ({desc_wr, full, used} !== {1'b0, 1'b1, 5'd16}) begin miscompares++; $display("FAIL simul_full_setup: got wr=%b full=%b used=%0d want 0 1 16", desc_wr, full, used); end
      wdata = 24'h0001FF; wr = 1'b1;
      step();
      wr = 1'b0;
      vectors++; if ({used, full, overflow, drop_cnt} !== {5'd15, 1'b0, 1'b1, 16'd2}) begin miscompares++; $display("FAIL simul_full_drop: got used=%0d full=%b ovf=%b cnt=%0d want 15 0 1 2", used, full, overflow, drop_cnt); end
      vectors++; if ({desc_wr, bufid} !== {1'b1, 9'h012}) begin miscompares++; $display("FAIL simul_full_pop: got wr=%b bufid=%h want 1 012", desc_wr, bufid); end
      for (int k = 8'h12; k <= 8'h21; k++) begin
         vectors++; if (bufid !== 9'(k)) begin miscompares++; $display("FAIL simul_drain_%0h: got %h want %h", k, bufid, 9'(k)); end
         ack = 1'b1;
         step();
         ack = 1'b0;
         step();
      end
      vectors++; if ({desc_wr, used} !== {1'b0, 5'd0}) begin miscompares++; $display("FAIL simul_drained: got wr=%b used=%0d want 0 0", desc_wr, used); end
   endtask

   task automatic test_spurious_ack();
      ack = 1'b1;
      for (int c = 0; c < 3; c++) begin
         step();
         vectors++; if ({desc_wr, used, bufid} !== {1'b0, 5'd0, 9'h021}) begin miscompares++; $display("FAIL spurious_%0d: got wr=%b used=%0d bufid=%h want 0 0 021", c, desc_wr, used, bufid); end
      end
      ack = 1'b0;
   endtask

   task automatic test_reset_in_wait();
      for (int i = 0; i < 4; i++) begin
         wdata = 24'(8'h30 + i); wr = 1'b1;
         step();
      end
      wr = 1'b0;
      vectors++; if ({desc_wr, used, bufid} !== {1'b1, 5'd3, 9'h030}) begin miscompares++; $display("FAIL rstwait_setup: got wr=%b used=%0d bufid=%h want 1 3 030", desc_wr, used, bufid); end
      rst = 1'b1;
      step();
      rst = 1'b0;
      vectors++; if ({desc_wr, full, overflow, used} !== {1'b0, 1'b0, 1'b0, 5'd0}) begin miscompares++; $display("FAIL rstwait_ctrl: got wr=%b full=%b ovf=%b used=%0d want 0 0 0 0", desc_wr, full, overflow, used); end
      vectors++; if ({flag, flowid, bufid} !== 24'h0) begin miscompares++; $display("FAIL rstwait_fields: got %h want 000000", {flag, flowid, bufid}); end
      vectors++; if (drop_cnt !== 16'd0) begin miscompares++; $display("FAIL rstwait_drop_cnt: got %0d want 0", drop_cnt); end
      ack = 1'b1;
      step();
      ack = 1'b0;
      vectors++; if ({desc_wr, used} !== {1'b0, 5'd0}) begin miscompares++; $display("FAIL rstwait_late_ack: got wr=%b used=%0d want 0 0", desc_wr, used); end
      wdata = 24'h000007; wr = 1'b1;
      step();
      wr = 1'b0;
      step();
      vectors++; if ({desc_wr, flag, flowid, bufid, used} !== {1'b1, 1'b0, 14'h0, 9'h007, 5'd0}) begin miscompares++; $display("FAIL rstwait_after: got wr=%b f=%b fl=%h b=%h u=%0d want 1 0 0000 007 0", desc_wr, flag, flowid, bufid, used); end
      ack = 1'b1;
      step();
      ack = 1'b0;
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_delayed_ack();
      test_simultaneous();
      test_spurious_ack();
      test_reset_in_wait();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
